// File: rtl/nn_pkg.sv
// Shared numeric types for the classifier datapath.
// Scores are signed two's complement; SCORE_MIN seeds running-comparison logic.
package nn_pkg;
    localparam int SCORE_W = 16;

    typedef logic signed [SCORE_W-1:0] score_t;

    localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
endpackage

// File: rtl/argmax_stream.sv
// Streaming argmax: tracks running max and runner-up over NUM_CLASSES scores,
// then holds winning index, score and margin on a valid/ready result port.
module argmax_stream
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter bit TIE_HIGH    = 1'b1,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [IDX_W-1:0]  m_class_idx,
    output logic [DATA_W-1:0] m_max_score,
    output logic [DATA_W:0]   m_margin,
    output logic              m_err
);
    generate
        if (NUM_CLASSES < 2) begin : g_bad_num_classes
            $error("argmax_stream: NUM_CLASSES must be >= 2");
        end
    endgenerate

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    // Most negative DATA_W value; matches the shared SCORE_MIN at the native width.
    localparam logic signed [DATA_W-1:0] RUNNER_SEED = (DATA_W == SCORE_W)
        ? DATA_W'(SCORE_MIN) : {1'b1, {(DATA_W-1){1'b0}}};

    state_t                    state_reg, state_next;
    logic [IDX_W-1:0]          cnt_reg, cnt_next;
    logic signed [DATA_W-1:0]  max_reg, max_next;
    logic signed [DATA_W-1:0]  runner_reg, runner_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;
    logic                      err_reg, err_next;
    logic [DATA_W:0]           margin_next;

    logic                      m_valid_reg;
    logic [IDX_W-1:0]          m_class_idx_reg;
    logic [DATA_W-1:0]         m_max_score_reg;
    logic [DATA_W:0]           m_margin_reg;
    logic                      m_err_reg;

    logic                      beat;
    logic                      is_first;
    logic                      is_final;
    logic                      replace;
    logic signed [DATA_W-1:0]  data_s;

    assign s_ready  = (state_reg == COLLECT);
    assign beat     = s_valid && s_ready;
    assign is_first = (cnt_reg == '0);
    assign is_final = (cnt_reg == LAST_IDX);
    assign data_s   = $signed(s_data);
    assign replace  = TIE_HIGH ? (data_s >= max_reg) : (data_s > max_reg);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        max_next    = max_reg;
        runner_next = runner_reg;
        idx_next    = idx_reg;
        err_next    = err_reg;
        case (state_reg)
            COLLECT: begin
                if (beat) begin
                    if (is_first) begin
                        max_next    = data_s;
                        idx_next    = '0;
                        runner_next = RUNNER_SEED;
                    end else if (replace) begin
                        runner_next = max_reg;
                        max_next    = data_s;
                        idx_next    = cnt_reg;
                    end else if (data_s > runner_reg) begin
                        runner_next = data_s;
                    end
                    // Framing error: s_last must be set exactly on the final beat.
                    err_next = (is_first ? 1'b0 : err_reg) | (s_last != is_final);
                    if (is_final) begin
                        cnt_next   = '0;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Sign-extend both operands so the difference never wraps.
    assign margin_next = {max_next[DATA_W-1], max_next} - {runner_next[DATA_W-1], runner_next};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= COLLECT;
            cnt_reg         <= '0;
            max_reg         <= '0;
            runner_reg      <= '0;
            idx_reg         <= '0;
            err_reg         <= 1'b0;
            m_valid_reg     <= 1'b0;
            m_class_idx_reg <= '0;
            m_max_score_reg <= '0;
            m_margin_reg    <= '0;
            m_err_reg       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            max_reg    <= max_next;
            runner_reg <= runner_next;
            idx_reg    <= idx_next;
            err_reg    <= err_next;
            if (beat && is_final) begin
                m_valid_reg     <= 1'b1;
                m_class_idx_reg <= idx_next;
                m_max_score_reg <= max_next;
                m_margin_reg    <= margin_next;
                m_err_reg       <= err_next;
            end else if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_valid     = m_valid_reg;
    assign m_class_idx = m_class_idx_reg;
    assign m_max_score = m_max_score_reg;
    assign m_margin    = m_margin_reg;
    assign m_err       = m_err_reg;
endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: two instances (TIE_HIGH=1 and 0) share one
// input stream so tie behaviour of both rules is checked on the same frames.
module tb_argmax_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready_hi, m_valid_hi, m_err_hi;
    logic [1:0]  idx_hi;
    logic [15:0] max_hi;
    logic [16:0] margin_hi;
    logic        s_ready_lo, m_valid_lo, m_err_lo;
    logic [1:0]  idx_lo;
    logic [15:0] max_lo;
    logic [16:0] margin_lo;

    int n_compared = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    argmax_stream #(.NUM_CLASSES(4), .DATA_W(16), .TIE_HIGH(1'b1)) dut_hi (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready_hi), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_hi), .m_ready(m_ready), .m_class_idx(idx_hi),
        .m_max_score(max_hi), .m_margin(margin_hi), .m_err(m_err_hi)
    );

    argmax_stream #(.NUM_CLASSES(4), .DATA_W(16), .TIE_HIGH(1'b0)) dut_lo (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready_lo), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_lo), .m_ready(m_ready), .m_class_idx(idx_lo),
        .m_max_score(max_lo), .m_margin(margin_lo), .m_err(m_err_lo)
    );

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic send_beat(input logic [15:0] data, input logic last, input int gap);
        int budget;
        repeat (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        budget  = 0;
        while (!s_ready_hi && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        n_compared++;
        if (!s_ready_hi) begin
            n_mismatched++;
            $display("FAIL beat_accept_timeout: s_ready=%b required 1", s_ready_hi);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [3:0] last_mask, input int gap);
        send_beat(d0, last_mask[0], 0);
        send_beat(d1, last_mask[1], gap);
        send_beat(d2, last_mask[2], gap);
        send_beat(d3, last_mask[3], gap);
        s_valid = 1'b0;
        s_last  = 1'b0;
        $display("frame %0d %0d %0d %0d -> hi idx=%0d max=%0d margin=%0d err=%b | lo idx=%0d margin=%0d",
                 $signed(d0), $signed(d1), $signed(d2), $signed(d3),
                 idx_hi, $signed(max_hi), margin_hi, m_err_hi, idx_lo, margin_lo);
    endtask

    task automatic handshake(input string name);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        n_compared++;
        if (m_valid_hi !== 1'b0 || s_ready_hi !== 1'b1 || m_valid_lo !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s_handshake: m_valid=%b s_ready=%b required m_valid=0 s_ready=1",
                     name, m_valid_hi, s_ready_hi);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_compared++;
        if ({m_valid_hi, idx_hi, max_hi, margin_hi, m_err_hi} !== '0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got v=%b idx=%0d max=%0d margin=%0d err=%b required all 0",
                     m_valid_hi, idx_hi, max_hi, margin_hi, m_err_hi);
        end
        n_compared++;
        if (s_ready_hi !== 1'b1 || s_ready_lo !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_s_ready: got %b/%b required 1", s_ready_hi, s_ready_lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        send_frame(16'd5, -16'sd3, 16'd12, 16'd7, 4'b1000, 0);
        n_compared++;
        if (m_valid_hi !== 1'b1 || idx_hi !== 2'd2 || max_hi !== 16'd12 ||
            margin_hi !== 17'd5 || m_err_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL basic_hi: v=%b idx=%0d max=%0d margin=%0d err=%b required 1/2/12/5/0",
                     m_valid_hi, idx_hi, max_hi, margin_hi, m_err_hi);
        end
        n_compared++;
        if (idx_lo !== 2'd2 || margin_lo !== 17'd5) begin
            n_mismatched++;
            $display("FAIL basic_lo: idx=%0d margin=%0d required 2/5", idx_lo, margin_lo);
        end
        n_compared++;
        if (s_ready_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL basic_hold_ready: s_ready=%b required 0", s_ready_hi);
        end
        handshake("basic");
    endtask

    task automatic test_tie;
        send_frame(16'd9, 16'd9, 16'd1, 16'd0, 4'b1000, 0);
        n_compared++;
        if (idx_hi !== 2'd1 || margin_hi !== 17'd0 || max_hi !== 16'd9) begin
            n_mismatched++;
            $display("FAIL tie_high: idx=%0d margin=%0d max=%0d required 1/0/9", idx_hi, margin_hi, max_hi);
        end
        n_compared++;
        if (idx_lo !== 2'd0 || margin_lo !== 17'd0) begin
            n_mismatched++;
            $display("FAIL tie_low: idx=%0d margin=%0d required 0/0", idx_lo, margin_lo);
        end
        handshake("tie");
    endtask

    task automatic test_extremes;
        send_frame(16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 4'b1000, 0);
        n_compared++;
        if (idx_hi !== 2'd1 || max_hi !== 16'h7FFF || margin_hi !== 17'd65535) begin
            n_mismatched++;
            $display("FAIL extremes: idx=%0d max=%0d margin=%0d required 1/32767/65535",
                     idx_hi, $signed(max_hi), margin_hi);
        end
        handshake("extremes");
    endtask

    task automatic test_all_equal;
        send_frame(16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b1000, 0);
        n_compared++;
        if (idx_hi !== 2'd3 || margin_hi !== 17'd0 || max_hi !== 16'h8000) begin
            n_mismatched++;
            $display("FAIL all_equal_high: idx=%0d margin=%0d max=%0d required 3/0/-32768",
                     idx_hi, margin_hi, $signed(max_hi));
        end
        n_compared++;
        if (idx_lo !== 2'd0 || margin_lo !== 17'd0) begin
            n_mismatched++;
            $display("FAIL all_equal_low: idx=%0d margin=%0d required 0/0", idx_lo, margin_lo);
        end
        handshake("all_equal");
    endtask

    task automatic test_backpressure;
        send_frame(16'd1, 16'd2, 16'd3, 16'd4, 4'b1000, 0);
        s_valid = 1'b1;
        s_data  = 16'd100;
        s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_compared++;
            if (s_ready_hi !== 1'b0 || m_valid_hi !== 1'b1 || idx_hi !== 2'd3 ||
                max_hi !== 16'd4 || margin_hi !== 17'd1) begin
                n_mismatched++;
                $display("FAIL backpressure_hold_%0d: rdy=%b v=%b idx=%0d max=%0d margin=%0d required 0/1/3/4/1",
                         c, s_ready_hi, m_valid_hi, idx_hi, max_hi, margin_hi);
            end
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        n_compared++;
        if (s_ready_hi !== 1'b1 || m_valid_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL backpressure_release: rdy=%b v=%b required 1/0", s_ready_hi, m_valid_hi);
        end
        // 100 is still on the bus and is now taken as index 0 of the next frame.
        @(posedge clk);
        @(negedge clk);
        send_beat(16'd50, 1'b0, 0);
        send_beat(16'd60, 1'b0, 2);
        send_beat(16'd70, 1'b1, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_compared++;
        if (m_valid_hi !== 1'b1 || idx_hi !== 2'd0 || max_hi !== 16'd100 ||
            margin_hi !== 17'd30 || m_err_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL backpressure_next_frame: v=%b idx=%0d max=%0d margin=%0d err=%b required 1/0/100/30/0",
                     m_valid_hi, idx_hi, max_hi, margin_hi, m_err_hi);
        end
        handshake("backpressure");
    endtask

    task automatic test_gaps;
        send_frame(16'd5, -16'sd3, 16'd12, 16'd7, 4'b1000, 3);
        n_compared++;
        if (idx_hi !== 2'd2 || max_hi !== 16'd12 || margin_hi !== 17'd5 || m_err_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL gaps: idx=%0d max=%0d margin=%0d err=%b required 2/12/5/0",
                     idx_hi, max_hi, margin_hi, m_err_hi);
        end
        handshake("gaps");
    endtask

    task automatic test_framing;
        send_beat(16'd5, 1'b0, 0);
        send_beat(-16'sd3, 1'b1, 0);
        send_beat(16'd12, 1'b0, 0);
        n_compared++;
        if (m_valid_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL framing_early_end: m_valid=%b after 3 beats required 0", m_valid_hi);
        end
        send_beat(16'd7, 1'b0, 0);
        s_valid = 1'b0;
        n_compared++;
        if (m_valid_hi !== 1'b1 || m_err_hi !== 1'b1 || idx_hi !== 2'd2 || m_err_lo !== 1'b1) begin
            n_mismatched++;
            $display("FAIL framing_err: v=%b err=%b idx=%0d err_lo=%b required 1/1/2/1",
                     m_valid_hi, m_err_hi, idx_hi, m_err_lo);
        end
        handshake("framing");
    endtask

    task automatic test_reset_midframe;
        send_beat(16'd1000, 1'b0, 0);
        send_beat(16'd2000, 1'b0, 0);
        s_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_compared++;
        if ({m_valid_hi, idx_hi, max_hi, margin_hi, m_err_hi} !== '0 || s_ready_hi !== 1'b1) begin
            n_mismatched++;
            $display("FAIL midframe_reset: v=%b idx=%0d max=%0d margin=%0d err=%b rdy=%b required 0s and rdy 1",
                     m_valid_hi, idx_hi, max_hi, margin_hi, m_err_hi, s_ready_hi);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_frame(-16'sd1, -16'sd5, -16'sd2, -16'sd9, 4'b1000, 0);
        n_compared++;
        if (m_valid_hi !== 1'b1 || idx_hi !== 2'd0 || max_hi !== 16'hFFFF ||
            margin_hi !== 17'd1 || m_err_hi !== 1'b0) begin
            n_mismatched++;
            $display("FAIL post_reset_frame: v=%b idx=%0d max=%0d margin=%0d err=%b required 1/0/-1/1/0",
                     m_valid_hi, idx_hi, $signed(max_hi), margin_hi, m_err_hi);
        end
        handshake("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_extremes();
        test_all_equal();
        test_backpressure();
        test_gaps();
        test_framing();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
